// File: rtl/rv32_pkg.sv
// Shared RV32 types for the writeback path: result source codes,
// load funct3 encodings and the datapath width.
package rv32_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load lane extraction and sign/zero extension of a raw memory word.
// Undefined funct3 codes behave as LW.
module load_align
   import rv32_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [2:0]   funct3,
   input  logic [1:0]   addr_lo,
   input  logic [W-1:0] rdata,
   output logic [W-1:0] data,
   output logic         misaligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[8*addr_lo +: 8];
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data       = rdata;
      misaligned = 1'b0;
      unique case (funct3)
         F3_LB:  data = {{(W-8){byte_v[7]}}, byte_v};
         F3_LBU: data = {{(W-8){1'b0}}, byte_v};
         F3_LH: begin
            data       = {{(W-16){half_v[15]}}, half_v};
            misaligned = addr_lo[0];
         end
         F3_LHU: begin
            data       = {{(W-16){1'b0}}, half_v};
            misaligned = addr_lo[0];
         end
         default: begin
            data       = rdata;
            misaligned = (addr_lo != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/wb_result_sel.sv
// Writeback register + result select; forwarding tap and instret counter.
// Define WB_MISALIGN_CHECK_EN to suppress and flag misaligned loads.
module wb_result_sel
   import rv32_pkg::*;
#(
   parameter int XLEN  = rv32_pkg::XLEN,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_reg_write,
   input  logic [4:0]       in_rd,
   input  logic [1:0]       in_result_src,
   input  logic [2:0]       in_funct3,
   input  logic [1:0]       in_addr_lo,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic [XLEN-1:0]  pc_plus4,
   input  logic [XLEN-1:0]  imm_val,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [XLEN-1:0]  rf_wdata,
   output logic             fwd_valid,
   output logic [CNT_W-1:0] instret,
   output logic             misalign_err
);

   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] sel_data;
   logic            ld_mis;
   logic            bad_ld;
   logic            we_d;
   result_src_t     src;

   load_align #(.W(XLEN)) u_align (
      .funct3     (in_funct3),
      .addr_lo    (in_addr_lo),
      .rdata      (mem_rdata),
      .data       (ld_data),
      .misaligned (ld_mis)
   );

   assign src = result_src_t'(in_result_src);

   always_comb begin
      sel_data = alu_result;
      unique case (src)
         RES_ALU: sel_data = alu_result;
         RES_MEM: sel_data = ld_data;
         RES_PC4: sel_data = pc_plus4;
         RES_IMM: sel_data = imm_val;
         default: sel_data = alu_result;
      endcase
   end

`ifdef WB_MISALIGN_CHECK_EN
   assign bad_ld = in_valid & (src == RES_MEM) & ld_mis;
`else
   logic unused_mis;
   assign unused_mis = ld_mis;
   assign bad_ld     = 1'b0;
`endif

   assign we_d = in_valid & in_reg_write & (in_rd != 5'd0) & ~bad_ld;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we        <= 1'b0;
         rf_waddr     <= 5'd0;
         rf_wdata     <= '0;
         instret      <= '0;
         misalign_err <= 1'b0;
      end else if (flush) begin
         rf_we        <= 1'b0;
         misalign_err <= 1'b0;
      end else if (!stall) begin
         rf_we        <= we_d;
         rf_waddr     <= in_rd;
         rf_wdata     <= sel_data;
         misalign_err <= bad_ld;
         if (in_valid)
            instret <= instret + 1'b1;
      end
   end

   assign fwd_valid = rf_we;

endmodule
